mips_mc_controller: RTL and testbench

- Multi-cycle MIPS control unit: main Moore FSM plus ALU-control decoder.
- Produces the 3-bit ALU operation select and all datapath enables/muxes.
- Consumes the ALU zero flag for branch resolution.
- Sits between the instruction register (op/funct) and the datapath/ALU.

---
 rtl/mips_mc_controller_if.sv | 31 +++
 rtl/mips_mc_controller.sv | 179 +++++++++++++++++
 tb/tb_mips_mc_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_mc_controller_if.sv
// Control-unit boundary: instruction fields and ALU flag in, datapath controls out.
// The controller takes the master modport; the datapath/IR side takes slave.
interface mips_mc_controller_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic [2:0] alucont;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic       pcen;
   logic       iord;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic [3:0] state;

   modport master (
      input  op, funct, zero,
      output alucont, alusrca, alusrcb, pcsrc, pcen, iord, memwrite,
             irwrite, regdst, memtoreg, regwrite, state
   );

   modport slave (
      output op, funct, zero,
      input  alucont, alusrca, alusrcb, pcsrc, pcen, iord, memwrite,
             irwrite, regdst, memtoreg, regwrite, state
   );
endinterface

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit: main Moore FSM plus ALU-control decode.
// Moore outputs are registered from the decode of the state being entered.
module mips_mc_controller (
   input  logic                       clk,
   input  logic                       reset,
   mips_mc_controller_if.master       bus
);
   typedef enum logic [3:0] {
      FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR  = 4'd2,  MEMRD  = 4'd3,
      MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6,  RTYPEWB = 4'd7,
      BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB  = 4'd10, JEX    = 4'd11,
      BNEEX   = 4'd12
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t     cur_state, nxt_state, load_state;

   logic [2:0] alucont_q,  d_alucont;
   logic       alusrca_q,  d_alusrca;
   logic [1:0] alusrcb_q,  d_alusrcb;
   logic [1:0] pcsrc_q,    d_pcsrc;
   logic       pcwrite_q,  d_pcwrite;
   logic       branch_q,   d_branch;
   logic       branchn_q,  d_branchn;
   logic       iord_q,     d_iord;
   logic       memwrite_q, d_memwrite;
   logic       irwrite_q,  d_irwrite;
   logic       regdst_q,   d_regdst;
   logic       memtoreg_q, d_memtoreg;
   logic       regwrite_q, d_regwrite;

   logic [2:0] funct_alu;
   logic       funct_ok;

   // R-type funct decode; unsupported functs default to ADD and skip writeback
   always_comb begin
      funct_alu = ALU_ADD;
      funct_ok  = 1'b1;
      case (bus.funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   // Next-state logic; unknown opcodes act as NOPs since PC already advanced
   always_comb begin
      nxt_state = FETCH;
      case (cur_state)
         FETCH:   nxt_state = DECODE;
         DECODE: begin
            case (bus.op)
               OP_LW, OP_SW: nxt_state = MEMADR;
               OP_R:         nxt_state = RTYPEEX;
               OP_BEQ:       nxt_state = BEQEX;
               OP_BNE:       nxt_state = BNEEX;
               OP_ADDI:      nxt_state = ADDIEX;
               OP_J:         nxt_state = JEX;
               default:      nxt_state = FETCH;
            endcase
         end
         MEMADR:  nxt_state = (bus.op == OP_SW) ? MEMWR : MEMRD;
         MEMRD:   nxt_state = MEMWB;
         RTYPEEX: nxt_state = funct_ok ? RTYPEWB : FETCH;
         ADDIEX:  nxt_state = ADDIWB;
         default: nxt_state = FETCH;
      endcase
   end

   assign load_state = reset ? FETCH : nxt_state;

   // Moore decode of the state about to be entered
   always_comb begin
      d_alucont  = ALU_ADD;
      d_alusrca  = 1'b0;
      d_alusrcb  = 2'b00;
      d_pcsrc    = 2'b00;
      d_pcwrite  = 1'b0;
      d_branch   = 1'b0;
      d_branchn  = 1'b0;
      d_iord     = 1'b0;
      d_memwrite = 1'b0;
      d_irwrite  = 1'b0;
      d_regdst   = 1'b0;
      d_memtoreg = 1'b0;
      d_regwrite = 1'b0;
      case (load_state)
         FETCH: begin
            d_alusrcb = 2'b01;
            d_irwrite = 1'b1;
            d_pcwrite = 1'b1;
         end
         DECODE:         d_alusrcb = 2'b11;
         MEMADR, ADDIEX: begin
            d_alusrca = 1'b1;
            d_alusrcb = 2'b10;
         end
         MEMRD:          d_iord = 1'b1;
         MEMWB: begin
            d_memtoreg = 1'b1;
            d_regwrite = 1'b1;
         end
         MEMWR: begin
            d_iord     = 1'b1;
            d_memwrite = 1'b1;
         end
         RTYPEEX: begin
            d_alusrca = 1'b1;
            d_alucont = funct_alu;
         end
         RTYPEWB: begin
            d_regdst   = 1'b1;
            d_regwrite = 1'b1;
         end
         BEQEX, BNEEX: begin
            d_alusrca = 1'b1;
            d_alucont = ALU_SUB;
            d_pcsrc   = 2'b01;
            d_branch  = (load_state == BEQEX);
            d_branchn = (load_state == BNEEX);
         end
         ADDIWB:         d_regwrite = 1'b1;
         JEX: begin
            d_pcsrc   = 2'b10;
            d_pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) cur_state <= FETCH;
      else       cur_state <= nxt_state;
      alucont_q  <= d_alucont;
      alusrca_q  <= d_alusrca;
      alusrcb_q  <= d_alusrcb;
      pcsrc_q    <= d_pcsrc;
      pcwrite_q  <= d_pcwrite;
      branch_q   <= d_branch;
      branchn_q  <= d_branchn;
      iord_q     <= d_iord;
      memwrite_q <= d_memwrite;
      irwrite_q  <= d_irwrite;
      regdst_q   <= d_regdst;
      memtoreg_q <= d_memtoreg;
      regwrite_q <= d_regwrite;
   end

   // Write enables are suppressed for the whole reset cycle, whatever the state
   assign bus.pcen     = ~reset & (pcwrite_q | (branch_q & bus.zero) | (branchn_q & ~bus.zero));
   assign bus.irwrite  = ~reset & irwrite_q;
   assign bus.memwrite = ~reset & memwrite_q;
   assign bus.regwrite = ~reset & regwrite_q;

   assign bus.alucont  = alucont_q;
   assign bus.alusrca  = alusrca_q;
   assign bus.alusrcb  = alusrcb_q;
   assign bus.pcsrc    = pcsrc_q;
   assign bus.iord     = iord_q;
   assign bus.regdst   = regdst_q;
   assign bus.memtoreg = memtoreg_q;
   assign bus.state    = cur_state;
endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed table-driven bench for the multi-cycle MIPS controller.
module tb_mips_mc_controller;
   logic clk = 1'b0;
   logic reset;

   mips_mc_controller_if bus ();

   mips_mc_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Output word: {alucont, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite}
   localparam logic [14:0] E_FETCH     = {3'b010, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_FETCH_RST = {3'b010, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_DECODE    = {3'b010, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_MEMADR    = {3'b010, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_MEMRD     = {3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_MEMWB     = {3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   localparam logic [14:0] E_MEMWB_RST = {3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam logic [14:0] E_MEMWR     = {3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_R_ADD     = {3'b010, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_R_SUB     = {3'b110, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_R_AND     = {3'b000, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_R_OR      = {3'b001, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_R_SLT     = {3'b111, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_RTWB      = {3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   localparam logic [14:0] E_BR_T      = {3'b110, 1'b1, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_BR_NT     = {3'b110, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_ADDIWB    = {3'b010, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [14:0] E_JEX       = {3'b010, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [5:0]  funct;
      logic        zero;
      logic [3:0]  st;
      logic [14:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   passed = 0;
   int   total  = 0;

   task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                      input logic zero, input logic [3:0] st, input logic [14:0] exp);
      vec_t v;
      v.rst = rst; v.op = op; v.funct = funct; v.zero = zero; v.st = st; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic rtype(input logic [5:0] funct, input logic [14:0] ex);
      add(1'b0, OP_R, funct, 1'b0, 4'd0, E_FETCH);
      add(1'b0, OP_R, funct, 1'b0, 4'd1, E_DECODE);
      add(1'b0, OP_R, funct, 1'b0, 4'd6, ex);
      add(1'b0, OP_R, funct, 1'b0, 4'd7, E_RTWB);
   endtask

   task automatic branch(input logic [5:0] op, input logic zero, input logic [3:0] st,
                         input logic [14:0] ex);
      add(1'b0, op, 6'd0, zero, 4'd0, E_FETCH);
      add(1'b0, op, 6'd0, zero, 4'd1, E_DECODE);
      add(1'b0, op, 6'd0, zero, st, ex);
   endtask

   function automatic logic [14:0] outs();
      return {bus.alucont, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.pcen, bus.iord,
              bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite};
   endfunction

   initial begin
      reset     = 1'b1;
      bus.op    = OP_LW;
      bus.funct = 6'd0;
      bus.zero  = 1'b0;

      // Second reset cycle, then LW
      add(1'b1, OP_LW, 6'd0, 1'b0, 4'd0, E_FETCH_RST);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd0, E_FETCH);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd1, E_DECODE);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd2, E_MEMADR);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd3, E_MEMRD);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd4, E_MEMWB);
      rtype(6'b100000, E_R_ADD);
      rtype(6'b100010, E_R_SUB);
      rtype(6'b100100, E_R_AND);
      rtype(6'b100101, E_R_OR);
      rtype(6'b101010, E_R_SLT);
      branch(OP_BEQ, 1'b1, 4'd8,  E_BR_T);
      branch(OP_BEQ, 1'b0, 4'd8,  E_BR_NT);
      branch(OP_BNE, 1'b0, 4'd12, E_BR_T);
      branch(OP_BNE, 1'b1, 4'd12, E_BR_NT);
      add(1'b0, OP_SW, 6'd0, 1'b0, 4'd0, E_FETCH);
      add(1'b0, OP_SW, 6'd0, 1'b0, 4'd1, E_DECODE);
      add(1'b0, OP_SW, 6'd0, 1'b0, 4'd2, E_MEMADR);
      add(1'b0, OP_SW, 6'd0, 1'b0, 4'd5, E_MEMWR);
      branch(OP_J, 1'b0, 4'd11, E_JEX);
      add(1'b0, OP_BAD, 6'd0, 1'b0, 4'd0, E_FETCH);
      add(1'b0, OP_BAD, 6'd0, 1'b0, 4'd1, E_DECODE);
      // Unsupported funct: ADD select, no writeback
      add(1'b0, OP_R, 6'b000000, 1'b0, 4'd0, E_FETCH);
      add(1'b0, OP_R, 6'b000000, 1'b0, 4'd1, E_DECODE);
      add(1'b0, OP_R, 6'b000000, 1'b0, 4'd6, E_R_ADD);
      add(1'b0, OP_ADDI, 6'd0, 1'b0, 4'd0, E_FETCH);
      add(1'b0, OP_ADDI, 6'd0, 1'b0, 4'd1, E_DECODE);
      add(1'b0, OP_ADDI, 6'd0, 1'b0, 4'd9, E_MEMADR);
      add(1'b0, OP_ADDI, 6'd0, 1'b0, 4'd10, E_ADDIWB);
      // LW aborted by reset in MEMRD
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd0, E_FETCH);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd1, E_DECODE);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd2, E_MEMADR);
      add(1'b1, OP_LW, 6'd0, 1'b0, 4'd3, E_MEMRD);
      // LW with reset landing in MEMWB: regwrite must stay low
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd0, E_FETCH);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd1, E_DECODE);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd2, E_MEMADR);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd3, E_MEMRD);
      add(1'b1, OP_LW, 6'd0, 1'b0, 4'd4, E_MEMWB_RST);
      add(1'b0, OP_LW, 6'd0, 1'b0, 4'd0, E_FETCH);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset     = vecs[i].rst;
         bus.op    = vecs[i].op;
         bus.funct = vecs[i].funct;
         bus.zero  = vecs[i].zero;
         #1;
         total++;
         if (bus.state === vecs[i].st) passed++;
         else $display("FAIL state vec%0d: got %0d want %0d", i, bus.state, vecs[i].st);
         total++;
         if (outs() === vecs[i].exp) passed++;
         else $display("FAIL outputs vec%0d (state %0d): got %b want %b",
                       i, vecs[i].st, outs(), vecs[i].exp);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
